cpu_bus_arbiter: RTL and testbench

Two-requester arbiter sharing the CPU's single external bus between the data-side path (write-back data cache) and the instruction-fetch path. Grants are round-robin, locked for a whole transaction, and the winner's command is captured at grant time. A watchdog aborts any transaction the bus never completes. The block sits between the CPU cache front-ends and the system bus, using the same request/ready handshake on every side.

---
 rtl/cpu_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one external bus between the data-side and
// instruction-fetch requesters, with a per-transaction watchdog abort.
module cpu_bus_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_d_request,
   input  logic        i_d_rw,
   input  logic [31:0] i_d_address,
   input  logic [31:0] i_d_wdata,
   output logic        o_d_ready,
   output logic [31:0] o_d_rdata,
   input  logic        i_i_request,
   input  logic        i_i_rw,
   input  logic [31:0] i_i_address,
   input  logic [31:0] i_i_wdata,
   output logic        o_i_ready,
   output logic [31:0] o_i_rdata,
   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rdata,
   output logic        o_busy,
   output logic        o_timeout
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic GRANT_D = 1'b0;
   localparam logic GRANT_I = 1'b1;

   logic [0:0]    state_q, state_d;
   logic          grant_q, grant_d;
   logic          last_grant_q, last_grant_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cmd_rw_q, cmd_rw_d;
   logic [31:0]   cmd_addr_q, cmd_addr_d;
   logic [31:0]   cmd_wdata_q, cmd_wdata_d;

   logic busy;
   logic winner;
   logic complete;
   logic abort;
   logic finish;

   assign busy = (state_q == ST_BUSY);

   // Next-state, grant selection, command capture and watchdog counting.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      cmd_rw_d     = cmd_rw_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      winner       = GRANT_D;
      case (state_q)
         ST_IDLE: begin
            // On a tie the side that did not win last time goes first.
            if (i_d_request && i_i_request) begin
               winner = ~last_grant_q;
            end else if (i_i_request) begin
               winner = GRANT_I;
            end else begin
               winner = GRANT_D;
            end
            if (i_d_request || i_i_request) begin
               grant_d = winner;
               cnt_d   = {CW{1'b0}};
               state_d = ST_BUSY;
               if (winner == GRANT_I) begin
                  cmd_rw_d    = i_i_rw;
                  cmd_addr_d  = i_i_address;
                  cmd_wdata_d = i_i_wdata;
               end else begin
                  cmd_rw_d    = i_d_rw;
                  cmd_addr_d  = i_d_address;
                  cmd_wdata_d = i_d_wdata;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (i_bus_ready || (cnt_q == CNT_LAST)) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, grant history, watchdog and latched command registers.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= GRANT_D;
         last_grant_q <= GRANT_I;
         cnt_q        <= {CW{1'b0}};
         cmd_rw_q     <= 1'b0;
         cmd_addr_q   <= 32'd0;
         cmd_wdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         cmd_rw_q     <= cmd_rw_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
      end
   end

   // Completion strobes are combinational from the bus; an abort returns zero data.
   always_comb begin
      complete = busy && i_bus_ready;
      abort    = busy && !i_bus_ready && (cnt_q == CNT_LAST);
      finish   = complete || abort;

      o_d_ready = finish && (grant_q == GRANT_D);
      o_i_ready = finish && (grant_q == GRANT_I);

      if (complete && (grant_q == GRANT_D)) begin
         o_d_rdata = i_bus_rdata;
      end else begin
         o_d_rdata = 32'd0;
      end

      if (complete && (grant_q == GRANT_I)) begin
         o_i_rdata = i_bus_rdata;
      end else begin
         o_i_rdata = 32'd0;
      end

      o_timeout     = abort;
      o_bus_request = busy;
      o_bus_rw      = busy && cmd_rw_q;
      if (busy) begin
         o_bus_address = cmd_addr_q;
         o_bus_wdata   = cmd_wdata_q;
      end else begin
         o_bus_address = 32'd0;
         o_bus_wdata   = 32'd0;
      end
   end

   assign o_busy = busy;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed, table-driven bench for cpu_bus_arbiter (TIMEOUT=8), plus hand
// sequences for command latching, watchdog abort and mid-transaction reset.
module tb_cpu_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        d_req, d_rw, i_req, i_rw, b_rdy;
   logic [31:0] d_addr, d_wdata, i_addr, i_wdata, b_rdata;
   logic        d_ready, i_ready, b_req, b_rw, busy, tmo;
   logic [31:0] d_rdata, i_rdata, b_addr, b_wdata;

   int n_applied = 0;
   int n_miscmp  = 0;

   typedef struct {
      logic        d_req;
      logic        d_rw;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        i_req;
      logic        i_rw;
      logic [31:0] i_addr;
      logic [31:0] i_wdata;
      logic        brdy;
      logic [31:0] brdata;
      logic        e_req;
      logic        e_rw;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_drdy;
      logic [31:0] e_drdata;
      logic        e_irdy;
      logic [31:0] e_irdata;
      logic        e_busy;
      logic        e_tmo;
   } vec_t;

   vec_t tbl[$];

   cpu_bus_arbiter #(.TIMEOUT(8)) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_d_request   (d_req),
      .i_d_rw        (d_rw),
      .i_d_address   (d_addr),
      .i_d_wdata     (d_wdata),
      .o_d_ready     (d_ready),
      .o_d_rdata     (d_rdata),
      .i_i_request   (i_req),
      .i_i_rw        (i_rw),
      .i_i_address   (i_addr),
      .i_i_wdata     (i_wdata),
      .o_i_ready     (i_ready),
      .o_i_rdata     (i_rdata),
      .o_bus_request (b_req),
      .o_bus_rw      (b_rw),
      .o_bus_address (b_addr),
      .o_bus_wdata   (b_wdata),
      .i_bus_ready   (b_rdy),
      .i_bus_rdata   (b_rdata),
      .o_busy        (busy),
      .o_timeout     (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs only; every expected output defaults to idle (all zero).
   function automatic vec_t f_in(input logic dq, input logic drw, input logic [31:0] da,
                                 input logic [31:0] dw, input logic iq, input logic irw,
                                 input logic [31:0] ia, input logic [31:0] iw,
                                 input logic br, input logic [31:0] bd);
      vec_t v;
      v.d_req = dq; v.d_rw = drw; v.d_addr = da; v.d_wdata = dw;
      v.i_req = iq; v.i_rw = irw; v.i_addr = ia; v.i_wdata = iw;
      v.brdy = br; v.brdata = bd;
      v.e_req = 1'b0; v.e_rw = 1'b0; v.e_addr = 32'd0; v.e_wdata = 32'd0;
      v.e_drdy = 1'b0; v.e_drdata = 32'd0; v.e_irdy = 1'b0; v.e_irdata = 32'd0;
      v.e_busy = 1'b0; v.e_tmo = 1'b0;
      return v;
   endfunction

   function automatic vec_t f_bus(input vec_t vi, input logic rw, input logic [31:0] a,
                                  input logic [31:0] w);
      vec_t v = vi;
      v.e_req = 1'b1; v.e_rw = rw; v.e_addr = a; v.e_wdata = w; v.e_busy = 1'b1;
      return v;
   endfunction

   function automatic vec_t f_drdy(input vec_t vi, input logic [31:0] r);
      vec_t v = vi;
      v.e_drdy = 1'b1; v.e_drdata = r;
      return v;
   endfunction

   function automatic vec_t f_irdy(input vec_t vi, input logic [31:0] r);
      vec_t v = vi;
      v.e_irdy = 1'b1; v.e_irdata = r;
      return v;
   endfunction

   function automatic vec_t f_tmo(input vec_t vi);
      vec_t v = vi;
      v.e_tmo = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_in(input vec_t v);
      d_req = v.d_req; d_rw = v.d_rw; d_addr = v.d_addr; d_wdata = v.d_wdata;
      i_req = v.i_req; i_rw = v.i_rw; i_addr = v.i_addr; i_wdata = v.i_wdata;
      b_rdy = v.brdy;  b_rdata = v.brdata;
   endtask

   task automatic cmp_out(input string tag, input vec_t v);
      chk({tag, ".bus_req"},   {31'd0, b_req},   {31'd0, v.e_req});
      chk({tag, ".bus_rw"},    {31'd0, b_rw},    {31'd0, v.e_rw});
      chk({tag, ".bus_addr"},  b_addr,           v.e_addr);
      chk({tag, ".bus_wdata"}, b_wdata,          v.e_wdata);
      chk({tag, ".d_ready"},   {31'd0, d_ready}, {31'd0, v.e_drdy});
      chk({tag, ".d_rdata"},   d_rdata,          v.e_drdata);
      chk({tag, ".i_ready"},   {31'd0, i_ready}, {31'd0, v.e_irdy});
      chk({tag, ".i_rdata"},   i_rdata,          v.e_irdata);
      chk({tag, ".busy"},      {31'd0, busy},    {31'd0, v.e_busy});
      chk({tag, ".timeout"},   {31'd0, tmo},     {31'd0, v.e_tmo});
   endtask

   // One clock cycle: drive, sample on the falling edge, advance past the rising edge.
   task automatic run_vec(input string tag, input vec_t v);
      apply_in(v);
      @(negedge clk);
      cmp_out(tag, v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t z;
      vec_t v;
      z = f_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

      // Tie with bus latency 1: data, instr, data, instr, one IDLE cycle apart.
      v = f_in(1'b1, 1'b0, 32'h100, 32'hD0, 1'b1, 1'b0, 32'h200, 32'h10, 1'b0, 32'd0);
      tbl.push_back(v);
      tbl.push_back(f_drdy(f_bus(f_in(1'b1, 1'b0, 32'h100, 32'hD0, 1'b1, 1'b0, 32'h200, 32'h10, 1'b1, 32'hA1), 1'b0, 32'h100, 32'hD0), 32'hA1));
      tbl.push_back(v);
      tbl.push_back(f_irdy(f_bus(f_in(1'b1, 1'b0, 32'h100, 32'hD0, 1'b1, 1'b0, 32'h200, 32'h10, 1'b1, 32'hB2), 1'b0, 32'h200, 32'h10), 32'hB2));
      tbl.push_back(v);
      tbl.push_back(f_drdy(f_bus(f_in(1'b1, 1'b0, 32'h100, 32'hD0, 1'b1, 1'b0, 32'h200, 32'h10, 1'b1, 32'hC3), 1'b0, 32'h100, 32'hD0), 32'hC3));
      tbl.push_back(v);
      tbl.push_back(f_irdy(f_bus(f_in(1'b1, 1'b0, 32'h100, 32'hD0, 1'b1, 1'b0, 32'h200, 32'h10, 1'b1, 32'hE4), 1'b0, 32'h200, 32'h10), 32'hE4));
      tbl.push_back(z);
      // Single data read, bus answers in the 3rd BUSY cycle.
      v = f_in(1'b1, 1'b0, 32'h1000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      tbl.push_back(v);
      tbl.push_back(f_bus(v, 1'b0, 32'h1000, 32'd0));
      tbl.push_back(f_bus(v, 1'b0, 32'h1000, 32'd0));
      tbl.push_back(f_drdy(f_bus(f_in(1'b1, 1'b0, 32'h1000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hDEADBEEF), 1'b0, 32'h1000, 32'd0), 32'hDEADBEEF));
      tbl.push_back(z);
      // Stray bus ready while IDLE.
      tbl.push_back(f_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h77));
      tbl.push_back(z);

      rst = 1'b1;
      apply_in(f_in(1'b1, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1, 32'hEEEE, 32'hEEEE, 1'b1, 32'h1234));
      #3;
      cmp_out("reset", z);
      apply_in(z);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < tbl.size(); k++) begin
         run_vec($sformatf("tbl%0d", k), tbl[k]);
      end

      // Write latch: requester changes command and drops request while BUSY.
      run_vec("wr0", f_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'd0));
      v = f_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h80, 32'hFFFF0000, 1'b0, 32'd0);
      for (int k = 1; k <= 2; k++) begin
         run_vec($sformatf("wr%0d", k), f_bus(v, 1'b1, 32'h40, 32'h12345678));
      end
      v.brdy = 1'b1;
      v.brdata = 32'hABC;
      run_vec("wr3", f_irdy(f_bus(v, 1'b1, 32'h40, 32'h12345678), 32'hABC));
      run_vec("wr4", z);

      // Watchdog: data wins the tie, bus never readies, instr pending.
      v = f_in(1'b1, 1'b0, 32'h300, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0, 1'b0, 32'hBAD);
      run_vec("to0", v);
      for (int k = 1; k <= 7; k++) begin
         run_vec($sformatf("to%0d", k), f_bus(v, 1'b0, 32'h300, 32'd0));
      end
      run_vec("to8", f_tmo(f_drdy(f_bus(v, 1'b0, 32'h300, 32'd0), 32'd0)));
      v.d_req = 1'b0;
      run_vec("to9", v);
      v.brdy = 1'b1;
      v.brdata = 32'h600D;
      run_vec("to10", f_irdy(f_bus(v, 1'b0, 32'h400, 32'd0), 32'h600D));
      run_vec("to11", z);

      // Reset during an instr transaction that followed a data grant.
      v = f_in(1'b1, 1'b0, 32'h500, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      run_vec("rs0", v);
      v.brdy = 1'b1;
      v.brdata = 32'h1;
      run_vec("rs1", f_drdy(f_bus(v, 1'b0, 32'h500, 32'd0), 32'h1));
      v = f_in(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h600, 32'd0, 1'b0, 32'd0);
      run_vec("rs2", v);
      run_vec("rs3", f_bus(v, 1'b0, 32'h600, 32'd0));
      v.brdy = 1'b1;
      v.brdata = 32'h99;
      apply_in(v);
      #2;
      rst = 1'b1;
      #1;
      cmp_out("rs_async", z);
      @(negedge clk);
      cmp_out("rs_hold", z);
      @(negedge clk);
      rst = 1'b0;
      v = f_in(1'b1, 1'b0, 32'h700, 32'd0, 1'b1, 1'b0, 32'h800, 32'd0, 1'b0, 32'd0);
      apply_in(v);
      #1;
      cmp_out("rs_idle", v);
      @(posedge clk);
      #1;
      v.brdy = 1'b1;
      v.brdata = 32'h7777;
      run_vec("rs_tie", f_drdy(f_bus(v, 1'b0, 32'h700, 32'd0), 32'h7777));
      run_vec("rs_end", z);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
      $finish;
   end

endmodule
